iq_window_correlator: RTL and testbench



---
 rtl/iq_demod_pkg.sv | 38 +++
 rtl/corr_lane_sum.sv | 22 ++
 rtl/iq_window_correlator.sv | 122 ++++++++++++
 tb/tb_iq_window_correlator.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_demod_pkg.sv
// Shared constants, types and arithmetic helpers for the IQ demodulator
// window correlator.
package iq_demod_pkg;

    localparam int TAPS   = 20;
    localparam int LANES  = 4;
    localparam int SW     = 5;
    localparam int CW     = 10;
    localparam int STEPS  = TAPS / LANES;
    localparam int STEP_W = $clog2(STEPS);

    localparam logic [CW-1:0] THRESH_DEFAULT = 10'd200;

    typedef logic signed [SW-1:0] sample_t;
    typedef logic signed [CW-1:0] corr_t;
    typedef logic [STEP_W-1:0]    step_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } corr_state_t;

    function automatic corr_t sign_extend(input sample_t s);
        return {{(CW-SW){s[SW-1]}}, s};
    endfunction

    // One extra bit so the most negative correlation still has a representable magnitude.
    function automatic logic [CW:0] magnitude(input corr_t v);
        logic [CW:0] ext;
        ext = {v[CW-1], v};
        if (ext[CW]) begin
            return ~ext + {{CW{1'b0}}, 1'b1};
        end else begin
            return ext;
        end
    endfunction

endpackage

// File: rtl/corr_lane_sum.sv
// Combinational sum of LANES taps, each weighted +1 (chip bit 1) or -1 (chip bit 0).
module corr_lane_sum
    import iq_demod_pkg::*;
(
    input  logic [LANES-1:0][SW-1:0] taps,
    input  logic [LANES-1:0]         weights,
    output corr_t                    sum
);

    // Signed add/subtract of every lane into one corr_t result.
    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            if (weights[k]) begin
                sum = sum + sign_extend(taps[k]);
            end else begin
                sum = sum - sign_extend(taps[k]);
            end
        end
    end

endmodule

// File: rtl/iq_window_correlator.sv
// Serial +/-1 window correlator: snapshots TAPS samples and a chip pattern,
// accumulates LANES taps per clock and reports the sum with a threshold flag.
module iq_window_correlator
    import iq_demod_pkg::*;
#(
    parameter logic [CW-1:0] THRESH = THRESH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [TAPS-1:0][SW-1:0]  taps_i,
    input  logic [TAPS-1:0]          pattern_i,
    output corr_t                    corr_o,
    output logic                     corr_valid_o,
    output logic                     peak_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam step_t LAST_STEP = step_t'(STEPS - 1);

    corr_state_t state_r, state_next;
    step_t       step_r, step_next;
    corr_t       acc_r, acc_next;

    // Snapshot reshaped so each step selects one LANES-wide slice directly.
    logic [STEPS-1:0][LANES-1:0][SW-1:0] taps_r;
    logic [STEPS-1:0][LANES-1:0]         pattern_r;

    corr_t lane_sum_s;
    corr_t final_s;
    logic  load_s;
    logic  done_s;
    logic  reject_s;

    corr_lane_sum u_lane_sum (
        .taps    (taps_r[step_r]),
        .weights (pattern_r[step_r]),
        .sum     (lane_sum_s)
    );

    assign final_s = acc_r + lane_sum_s;

    // Next-state, accumulator and control strobes for the IDLE/ACC sequencer.
    always_comb begin
        state_next = state_r;
        step_next  = step_r;
        acc_next   = acc_r;
        load_s     = 1'b0;
        done_s     = 1'b0;
        reject_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    load_s     = 1'b1;
                    acc_next   = '0;
                    step_next  = '0;
                    state_next = ACC;
                end else begin
                    state_next = IDLE;
                end
            end
            ACC: begin
                if (step_r == LAST_STEP) begin
                    done_s    = 1'b1;
                    acc_next  = '0;
                    step_next = '0;
                    // A start on the final step chains the next window with no bubble.
                    if (start_i) begin
                        load_s     = 1'b1;
                        state_next = ACC;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    acc_next  = final_s;
                    step_next = step_r + step_t'(1);
                    reject_s  = start_i;
                end
            end
            default: begin
                state_next = IDLE;
                step_next  = '0;
                acc_next   = '0;
            end
        endcase
    end

    // State, snapshot and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            step_r       <= '0;
            acc_r        <= '0;
            taps_r       <= '0;
            pattern_r    <= '0;
            corr_o       <= '0;
            corr_valid_o <= 1'b0;
            peak_o       <= 1'b0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            state_r      <= state_next;
            step_r       <= step_next;
            acc_r        <= acc_next;
            busy_o       <= (state_next == ACC);
            corr_valid_o <= done_s;
            peak_o       <= done_s && (magnitude(final_s) >= {1'b0, THRESH});
            if (load_s) begin
                taps_r    <= taps_i;
                pattern_r <= pattern_i;
            end
            if (done_s) begin
                corr_o <= final_s;
            end
            if (reject_s) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iq_window_correlator.sv
// Self-checking bench: vector table, randomized windows against an arithmetic
// reference model, plus hand-written back-to-back, overrun and reset sequences.
module tb_iq_window_correlator;
    import iq_demod_pkg::*;

    typedef logic [TAPS-1:0][SW-1:0] taps_t;
    typedef logic [TAPS-1:0]         pat_t;

    typedef struct {
        taps_t taps;
        pat_t  pattern;
        int    exp_corr;
        bit    exp_peak;
        string name;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  start_i;
    taps_t taps_i;
    pat_t  pattern_i;
    corr_t corr_o;
    logic  corr_valid_o;
    logic  peak_o;
    logic  busy_o;
    logic  overrun_o;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit peak_q[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    iq_window_correlator dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .taps_i       (taps_i),
        .pattern_i    (pattern_i),
        .corr_o       (corr_o),
        .corr_valid_o (corr_valid_o),
        .peak_o       (peak_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    function automatic int ref_corr(input taps_t t, input pat_t p);
        int s;
        int v;
        s = 0;
        for (int i = 0; i < TAPS; i++) begin
            v = $signed(t[i]);
            s += p[i] ? v : -v;
        end
        return s;
    endfunction

    function automatic bit ref_peak(input int c);
        return ((c < 0) ? -c : c) >= 200;
    endfunction

    function automatic taps_t fill(input int v);
        taps_t t;
        for (int i = 0; i < TAPS; i++) t[i] = 5'(v);
        return t;
    endfunction

    function automatic taps_t rand_taps();
        taps_t t;
        for (int i = 0; i < TAPS; i++) t[i] = 5'($urandom_range(0, 31));
        return t;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One isolated window; cycle 0 is the cycle in which start_i is high.
    task automatic do_window(input taps_t t, input pat_t p, input int exp_corr, input bit exp_peak,
                             input string name);
        int busy_cnt;
        int early_valid;
        busy_cnt    = 0;
        early_valid = 0;
        @(negedge clk);
        taps_i    = t;
        pattern_i = p;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        taps_i    = rand_taps();
        pattern_i = pat_t'($urandom);
        for (int c = 1; c <= 5; c++) begin
            if (busy_o === 1'b1) busy_cnt++;
            if (corr_valid_o !== 1'b0) early_valid++;
            @(posedge clk);
            #1;
        end
        check({name, ".valid"}, corr_valid_o, 1);
        check({name, ".corr"}, $signed(corr_o), exp_corr);
        check({name, ".peak"}, peak_o, exp_peak);
        check({name, ".busy_done"}, busy_o, 0);
        check({name, ".busy_cycles"}, busy_cnt, 5);
        check({name, ".early_valid"}, early_valid, 0);
        @(posedge clk);
        #1;
        check({name, ".valid_pulse"}, corr_valid_o, 0);
        check({name, ".corr_hold"}, $signed(corr_o), exp_corr);
    endtask

    initial begin
        taps_t t;
        pat_t  p;
        int    nvalid;
        int    vcycle;
        int    vcorr;
        int    b2b_last;
        int    b2b_seen;

        reset     = 1'b1;
        start_i   = 1'b0;
        taps_i    = '0;
        pattern_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.corr", $signed(corr_o), 0);
        check("rst.valid", corr_valid_o, 0);
        check("rst.peak", peak_o, 0);
        check("rst.busy", busy_o, 0);
        check("rst.overrun", overrun_o, 0);
        @(negedge clk);
        reset = 1'b0;

        vecs[0] = '{fill(1),   20'hFFFFF, 20,   1'b0, "ones"};
        vecs[1] = '{fill(-16), 20'hFFFFF, -320, 1'b1, "neg_min"};
        vecs[2] = '{fill(-16), 20'h00000, 320,  1'b1, "neg_inv"};
        vecs[3] = '{fill(15),  20'hAAAAA, 0,    1'b0, "alt_zero"};
        vecs[4] = '{fill(10),  20'hFFFFF, 200,  1'b1, "thresh_eq"};
        t = fill(10);
        for (int i = 1; i < TAPS; i += 2) t[i] = 5'd9;
        vecs[5] = '{t, 20'hFFFFF, 190, 1'b0, "thresh_below"};
        for (int k = 6; k < 10; k++) begin
            t = rand_taps();
            p = pat_t'($urandom);
            vecs[k] = '{t, p, ref_corr(t, p), ref_peak(ref_corr(t, p)), $sformatf("rand%0d", k)};
        end
        for (int k = 0; k < 10; k++) begin
            do_window(vecs[k].taps, vecs[k].pattern, vecs[k].exp_corr, vecs[k].exp_peak, vecs[k].name);
        end
        check("single.overrun", overrun_o, 0);

        // Back-to-back windows at the 1-in-5 cadence.
        b2b_last = -1;
        b2b_seen = 0;
        fork
            begin
                for (int w = 0; w < 10; w++) begin
                    taps_t wt;
                    pat_t  wp;
                    @(negedge clk);
                    wt = rand_taps();
                    wp = pat_t'($urandom);
                    taps_i    = wt;
                    pattern_i = wp;
                    start_i   = 1'b1;
                    exp_q.push_back(ref_corr(wt, wp));
                    peak_q.push_back(ref_peak(ref_corr(wt, wp)));
                    @(posedge clk);
                    #1;
                    start_i   = 1'b0;
                    taps_i    = rand_taps();
                    pattern_i = pat_t'($urandom);
                    repeat (4) @(posedge clk);
                end
            end
            begin
                for (int c = 0; c < 70; c++) begin
                    @(posedge clk);
                    #1;
                    if (corr_valid_o === 1'b1) begin
                        if (exp_q.size() > 0) begin
                            check("b2b.corr", $signed(corr_o), exp_q.pop_front());
                            check("b2b.peak", peak_o, peak_q.pop_front());
                        end else begin
                            check("b2b.extra_valid", 1, 0);
                        end
                        if (b2b_last >= 0) check("b2b.spacing", c - b2b_last, 5);
                        b2b_last = c;
                        b2b_seen++;
                    end
                end
            end
        join
        check("b2b.count", b2b_seen, 10);
        check("b2b.overrun", overrun_o, 0);

        // Second start two cycles into a window must be rejected.
        @(negedge clk);
        taps_i    = fill(7);
        pattern_i = 20'hFFFFF;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        start_i   = 1'b1;
        taps_i    = fill(-16);
        pattern_i = 20'h00000;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        nvalid  = 0;
        vcycle  = -1;
        vcorr   = 0;
        for (int c = 3; c <= 14; c++) begin
            if (corr_valid_o === 1'b1) begin
                nvalid++;
                vcycle = c;
                vcorr  = $signed(corr_o);
            end
            @(posedge clk);
            #1;
        end
        check("ovr.valid_count", nvalid, 1);
        check("ovr.valid_cycle", vcycle, 6);
        check("ovr.corr", vcorr, 140);
        check("ovr.flag", overrun_o, 1);
        do_window(fill(3), 20'hFFFFF, 60, 1'b0, "post_ovr");
        check("ovr.sticky", overrun_o, 1);

        // Reset in the middle of accumulation discards the window.
        @(negedge clk);
        taps_i    = fill(5);
        pattern_i = 20'hFFFFF;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst.busy", busy_o, 0);
        check("mid_rst.corr", $signed(corr_o), 0);
        check("mid_rst.overrun", overrun_o, 0);
        @(negedge clk);
        reset  = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (corr_valid_o === 1'b1) nvalid++;
        end
        check("mid_rst.no_valid", nvalid, 0);
        check("mid_rst.idle", busy_o, 0);
        t = rand_taps();
        p = pat_t'($urandom);
        do_window(t, p, ref_corr(t, p), ref_peak(ref_corr(t, p)), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
